// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, responder on the core data-memory port.
// Optional interrupt output and IRQEN register are built when UART_TX_IRQ_EN is defined.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_en,
   input  logic [31:0] addr,
   input  logic [31:0] w_data,
   output logic [31:0] r_data,
   output logic        txd
`ifdef UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [7:0]    shifter, shifter_n;
   logic [15:0]   div_lat, div_n;
   logic [15:0]   baud_cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic          txd_n;
   logic          load;
   logic          pop, push;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full, busy, ovf;
   logic [15:0]   bauddiv;

   logic          sel;
   logic [1:0]    off;
   logic          wr_tx, wr_st, wr_div;
   logic          unused;

   assign sel    = (addr[31:4] == BASE_ADDR[31:4]);
   assign off    = addr[3:2];
   assign wr_tx  = w_en & sel & (off == 2'd0);
   assign wr_st  = w_en & sel & (off == 2'd1);
   assign wr_div = w_en & sel & (off == 2'd2);
   assign unused = ^{addr[1:0], w_data[31:16]};

   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);
   assign busy  = (state != IDLE);
   // A write into a full FIFO still lands if the FSM frees a slot in the same cycle.
   assign push  = wr_tx & (~full | pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= w_data[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Overflow set has priority over a software clear in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   ovf <= 1'b0;
      else if (wr_tx & ~push)      ovf <= 1'b1;
      else if (wr_st & w_data[3])  ovf <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       bauddiv <= DEFAULT_DIV;
      else if (wr_div) bauddiv <= w_data[15:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shifter  <= '0;
         div_lat  <= 16'd1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_n;
         shifter  <= shifter_n;
         div_lat  <= div_n;
         baud_cnt <= cnt_n;
         bit_idx  <= bit_n;
         txd      <= txd_n;
      end
   end

   always_comb begin
      state_n   = state;
      shifter_n = shifter;
      div_n     = div_lat;
      cnt_n     = baud_cnt;
      bit_n     = bit_idx;
      load      = 1'b0;
      pop       = 1'b0;
      txd_n     = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) load = 1'b1;
         end
         START: begin
            if (baud_cnt == 16'd0) begin
               state_n = DATA;
               bit_n   = 3'd0;
               cnt_n   = div_lat - 16'd1;
            end else begin
               cnt_n = baud_cnt - 16'd1;
            end
         end
         DATA: begin
            if (baud_cnt == 16'd0) begin
               cnt_n = div_lat - 16'd1;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 3'd1;
            end else begin
               cnt_n = baud_cnt - 16'd1;
            end
         end
         STOP: begin
            if (baud_cnt == 16'd0) begin
               if (!empty) load    = 1'b1;
               else        state_n = IDLE;
            end else begin
               cnt_n = baud_cnt - 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      // Divider is sampled only at frame start so mid-frame BAUDDIV writes wait a frame.
      if (load) begin
         pop       = 1'b1;
         shifter_n = mem[rd_ptr];
         div_n     = (bauddiv == 16'd0) ? 16'd1 : bauddiv;
         cnt_n     = div_n - 16'd1;
         state_n   = START;
      end
      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shifter_n[bit_n];
         default: txd_n = 1'b1;
      endcase
   end

`ifdef UART_TX_IRQ_EN
   logic irqen;
   logic wr_irqen;

   assign wr_irqen = w_en & sel & (off == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irqen <= 1'b0;
         irq   <= 1'b0;
      end else begin
         if (wr_irqen) irqen <= w_data[0];
         irq <= irqen & empty & ~busy;
      end
   end
`endif

   always_comb begin
      r_data = '0;
      if (sel) begin
         case (off)
            2'd1:    r_data = {24'b0, 4'(count), ovf, empty, full, busy};
            2'd2:    r_data = {16'b0, bauddiv};
`ifdef UART_TX_IRQ_EN
            2'd3:    r_data = {31'b0, irqen};
`endif
            default: r_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: serial frames are decoded by a monitor and matched
// against an expected queue of {divider, byte}; register behaviour is checked directly.
module tb_uart_tx_mmio;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        w_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] w_data = '0;
   logic [31:0] r_data;
   logic        txd;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   localparam logic [31:0] A_TX  = 32'h0000_1000;
   localparam logic [31:0] A_ST  = 32'h0000_1004;
   localparam logic [31:0] A_DIV = 32'h0000_1008;
   localparam logic [31:0] A_IE  = 32'h0000_100C;

   int total = 0;
   int bad   = 0;
   bit gapless = 1'b0;
   logic [23:0] exp_q[$];

   uart_tx_mmio dut (
      .clk    (clk),
      .reset  (rst),
      .w_en   (w_en),
      .addr   (addr),
      .w_data (w_data),
      .r_data (r_data),
      .txd    (txd)
`ifdef UART_TX_IRQ_EN
      ,
      .irq    (irq)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      w_en = 1'b1; addr = a; w_data = d;
      @(posedge clk);
      #1 w_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      addr = a;
      #1 check(tag, r_data, exp);
   endtask

   task automatic push_tx(input logic [7:0] b, input logic [15:0] d);
      exp_q.push_back({d, b});
      wr(A_TX, {24'b0, b});
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   // Frame monitor: samples txd at every falling clk edge across the whole frame.
   initial begin : mon
      logic [23:0] item;
      logic [9:0]  frame;
      logic [9:0]  obs;
      int          d, errs;
      bit          started, aborted;
      started = 1'b0;
      forever begin
         if (!started) begin
            @(negedge clk);
            if (rst || txd !== 1'b0) continue;
         end
         started = 1'b0;
         if (exp_q.size() == 0) begin
            check("unexpected_frame", exp_q.size(), 1);
            for (int k = 0; k < 5000 && txd === 1'b0; k++) @(negedge clk);
            continue;
         end
         item    = exp_q[0];
         d       = int'(item[23:8]);
         frame   = {1'b1, item[7:0], 1'b0};
         errs    = 0;
         obs     = '0;
         aborted = 1'b0;
         for (int c = 0; c < 10 * d; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) begin
               aborted = 1'b1;
               break;
            end
            if (txd !== frame[c / d]) errs++;
            if (c % d == d / 2) obs[c / d] = txd;
         end
         void'(exp_q.pop_front());
         if (!aborted) begin
            check("frame_byte", {24'b0, obs[8:1]}, {24'b0, item[7:0]});
            check("frame_start_stop", {30'b0, obs[9], obs[0]}, 32'd2);
            check("frame_timing", errs, 0);
            @(negedge clk);
            if (gapless && exp_q.size() != 0) check("frame_gap", {31'b0, txd}, 32'd0);
            started = !rst && (txd === 1'b0);
         end
      end
   end

   initial begin : stim
      int lows;
      // reset state
      repeat (3) @(negedge clk);
      check("rst_txd_held", {31'b0, txd}, 32'd1);
      rst = 1'b0;
      check("rst_txd", {31'b0, txd}, 32'd1);
      rd_chk("rst_status", A_ST, 32'h4);
      rd_chk("rst_div", A_DIV, 32'd434);
      rd_chk("rst_txdata_rd", A_TX, 32'd0);
      rd_chk("rst_irqen", A_IE, 32'd0);
`ifdef UART_TX_IRQ_EN
      check("rst_irq", {31'b0, irq}, 32'd0);
`endif

      // single frame, start latency and status during/after
      wr(A_DIV, 32'd4);
      rd_chk("t1_div", A_DIV, 32'd4);
      push_tx(8'h55, 16'd4);
      @(negedge clk);
      check("t1_txd_hold", {31'b0, txd}, 32'd1);
      @(negedge clk);
      check("t1_txd_start", {31'b0, txd}, 32'd0);
      rd_chk("t1_status_busy", A_ST, 32'h5);
      wait_drain("t1_drain", 200);
      rd_chk("t1_status_idle", A_ST, 32'h4);

      // fill FIFO, overflow, clear, gapless streaming
      gapless = 1'b1;
      for (int i = 0; i < 9; i++) push_tx(8'(i), 16'd4);
      wr(A_TX, 32'h09);
      rd_chk("t2_status_ovf", A_ST, 32'h8B);
      wr(A_ST, 32'h8);
      rd_chk("t2_status_clr", A_ST, 32'h83);
      wait_drain("t2_drain", 700);
      rd_chk("t2_status_idle", A_ST, 32'h4);

      // divider change mid-frame applies from the next frame
      push_tx(8'hA5, 16'd4);
      push_tx(8'h3C, 16'd8);
      repeat (10) @(negedge clk);
      wr(A_DIV, 32'd8);
      rd_chk("t3_div", A_DIV, 32'd8);
      wait_drain("t3_drain", 400);
      gapless = 1'b0;

      // asynchronous reset during data bit 3
      wr(A_DIV, 32'd4);
      push_tx(8'h55, 16'd4);
      for (int k = 0; k < 20 && txd !== 1'b0; k++) @(negedge clk);
      check("t4_start_seen", {31'b0, txd}, 32'd0);
      repeat (17) @(negedge clk);
      check("t4_bit3_low", {31'b0, txd}, 32'd0);
      #2 rst = 1'b1;
      #1 check("t4_async_txd", {31'b0, txd}, 32'd1);
      addr = A_ST;
      #1 check("t4_async_status", r_data, 32'h4);
      addr = A_DIV;
      #1 check("t4_async_div", r_data, 32'd434);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("t4_abandon", exp_q.size(), 0);

      // out-of-window write and IRQEN register
      wr(32'h0000_2000, 32'hAA);
      rd_chk("t5_out_rd", 32'h0000_2000, 32'd0);
      wr(A_IE, 32'd1);
`ifdef UART_TX_IRQ_EN
      rd_chk("t5_irqen", A_IE, 32'd1);
`else
      rd_chk("t5_irqen", A_IE, 32'd0);
`endif
      lows = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("t5_txd_quiet", lows, 0);
      rd_chk("t5_status", A_ST, 32'h4);

`ifdef UART_TX_IRQ_EN
      wr(A_DIV, 32'd4);
      repeat (2) @(negedge clk);
      check("t6_irq_idle", {31'b0, irq}, 32'd1);
      push_tx(8'hC3, 16'd4);
      @(negedge clk);
      @(negedge clk);
      check("t6_irq_busy", {31'b0, irq}, 32'd0);
      wait_drain("t6_drain", 200);
      repeat (3) @(negedge clk);
      check("t6_irq_done", {31'b0, irq}, 32'd1);
`endif

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
